// File: rtl/block_encoder_64to6_pkg.sv
// Shared cache constants, FSM state encoding and the 6-to-64 block-enable decoder.
// Pure declarations: no latency, no flow control.
package block_encoder_64to6_pkg;

    localparam int CACHE_SETS  = 64;
    localparam int CACHE_IDX_W = 6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } blk_state_e;

    function automatic logic [CACHE_SETS-1:0] blk_enable_decode(input logic [CACHE_IDX_W-1:0] idx);
        blk_enable_decode = {{(CACHE_SETS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/block_encoder_64to6_lse.sv
// Lowest-set-bit encoder: index of the least significant 1 plus a nonzero flag.
// Purely combinational, zero latency; no flow control.
module lowest_set_encoder64
    import block_encoder_64to6_pkg::*;
#(
    parameter int SETS  = CACHE_SETS,
    parameter int IDX_W = CACHE_IDX_W
) (
    input  logic [SETS-1:0]  i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_nz
);

    // Scan from the top so the lowest set bit is the last (winning) assignment.
    always_comb begin
        o_idx = '0;
        for (int i = SETS - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_nz = |i_vec;

endmodule

// File: rtl/block_encoder_64to6.sv
// Drains a multi-hot set mask as one set index per beat, lowest first; first beat one cycle after accept.
// out_ready=0 freezes the current beat; a new mask is taken only when idle.
module block_encoder_64to6
    import block_encoder_64to6_pkg::*;
#(
    parameter int SETS  = CACHE_SETS,
    parameter int IDX_W = CACHE_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SETS-1:0]  blockMask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] setBits,
    output logic             out_last,
    output logic             done
);

    localparam logic [SETS-1:0] ONE = SETS'(1);

    blk_state_e       r_state;
    blk_state_e       w_state_nxt;
    logic [SETS-1:0]  r_pending;
    logic [SETS-1:0]  w_pending_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic [IDX_W-1:0] w_low_idx;
    logic             w_low_nz;
    logic [SETS-1:0]  w_beat_clr;
    logic             w_emit;
    logic             w_single;

    // Encoder only ever sees registered state, so blockMask never reaches setBits.
    lowest_set_encoder64 #(
        .SETS  (SETS),
        .IDX_W (IDX_W)
    ) u_lse (
        .i_vec (r_pending),
        .o_idx (w_low_idx),
        .o_nz  (w_low_nz)
    );

    assign w_beat_clr = SETS'(blk_enable_decode(w_low_idx));
    assign w_emit     = (r_state == ST_EMIT) && w_low_nz;
    assign w_single   = ((r_pending & (r_pending - ONE)) == '0);

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = w_emit;
    assign setBits   = w_emit ? w_low_idx : '0;
    assign out_last  = w_emit && w_single;
    assign done      = r_done;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_pending_nxt = blockMask;
                    if (blockMask != '0) begin
                        w_state_nxt = ST_EMIT;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    w_pending_nxt = r_pending & ~w_beat_clr;
                    if (w_single) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_done    <= w_done_nxt;
        end
    end

endmodule

// File: doc/block_encoder_64to6.md
BLOCK_ENCODER_64TO6 -- requirements
Module: block_encoder_64to6

Interface
REQ-001 Parameter SETS, default 64: number of cache sets, which is the width of the block mask.
REQ-002 Parameter IDX_W, default 6: set-index width, equal to log2(SETS).
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  a block mask is offered.
REQ-006 in_ready  output  1  block is idle and can accept a mask.
REQ-007 blockMask  input  SETS  multi-hot set mask; bit i set means set i is pending.
REQ-008 out_valid  output  1  setBits holds a valid encoded index.
REQ-009 out_ready  input  1  consumer accepts the current index.
REQ-010 setBits  output  IDX_W  encoded set index, lowest pending bit first.
REQ-011 out_last  output  1  the current index is the final pending bit of the mask.
REQ-012 done  output  1  one-cycle pulse when a mask is fully drained.

Function
REQ-013 The block SHALL have two FSM states, IDLE and EMIT; in_ready SHALL be 1 exactly in IDLE.
REQ-014 On in_valid&&in_ready at edge N, the block SHALL register blockMask into a pending register.
- Nonzero mask: go to EMIT, with out_valid=1 from cycle N+1.
- Zero mask: stay in IDLE and assert done for cycle N+1 only.
REQ-015 In EMIT, setBits SHALL equal the index of the lowest set bit of pending, and out_valid SHALL be 1.
REQ-016 out_last SHALL be 1 when pending has exactly one bit set, i.e. (pending & (pending-1)) == 0.
REQ-017 On out_valid&&out_ready, the emitted bit SHALL be cleared from pending at that edge, sustaining one index per cycle under a continuous out_ready.
REQ-018 While out_valid=1 and out_ready=0, setBits, out_last and pending SHALL hold stable.
REQ-019 A handshake with out_last=1 SHALL return the FSM to IDLE, deassert out_valid and pulse done in the following cycle.
REQ-020 in_valid while in EMIT SHALL be ignored; blockMask is not sampled.
REQ-021 setBits SHALL be registered or derived only from registered pending; there SHALL be no combinational path from blockMask to setBits.
REQ-022 Indices SHALL be emitted in strictly ascending order, 0..SETS-1; bit SETS-1 SHALL encode to all-ones (63) without wrap-around.

Reset
REQ-023 While rst=1, outputs SHALL immediately read as follows:
- state=IDLE, pending=0
- in_ready=1, out_valid=0
- setBits=0, out_last=0, done=0
REQ-024 Reset asserted mid-stream SHALL discard remaining pending bits with no done pulse; after deassertion the block SHALL accept a new mask on the first edge.

Structure
REQ-025 SETS, IDX_W and the IDLE/EMIT state encoding SHALL live in the shared cache package, and the 6-to-64 block-enable decoder SHALL use the same constants.
REQ-026 Lowest-set-bit selection SHALL be a combinational sub-module, lowest_set_encoder64 (SETS-bit in, IDX_W-bit index out, plus a nonzero flag); the FSM and registers SHALL stay in block_encoder_64to6.

Verification
REQ-027 Single bit: mask=64'h1, out_ready=1 -> one beat setBits=0 with out_last=1, then done pulse; in_ready=1 again.
REQ-028 Sparse mask: mask=64'h8000_0001_0000_0402, out_ready=1 -> setBits 1, 10, 32, 63 on four consecutive cycles, out_last only on 63, then done.
REQ-029 Backpressure: mask=all-ones with out_ready alternating 1/0 -> 64 beats 0..63 in order, setBits held on every stall cycle, out_last only at 63.
REQ-030 Zero mask: mask=0 -> out_valid never rises, done pulses in cycle N+1, in_ready stays 1; a second in_valid during a stream is ignored.
REQ-031 Reset mid-stream: all-ones mask, rst pulsed after 3 beats -> out_valid=0 immediately with no done; then mask=64'h20 -> single beat setBits=5.
REQ-032 Round trip: random masks; the OR of the one-hot decodes of all emitted setBits SHALL equal the accepted mask, and the beat count SHALL equal its popcount.
